// File: rtl/vid_timing_out.sv
// Clocked-video output stage: programmable h/v timing, input pixel FIFO, frame-start lock
// with sticky underflow / SOP-EOP misalignment flags and automatic resynchronisation.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | counters and FIFO at reset, outputs inactive, wait for enable
// WAIT_SOP | timing runs, non-SOP heads discarded, lock SOP to pixel (0,0)
// RUN      | one FIFO entry popped per active pixel, errors checked
module vid_timing_out #(
  parameter int DATA_W     = 24,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 48,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 29,
  parameter int SYNC_POL   = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              vid_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic              din_ready,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_datavalid,
  output logic              vid_h_sync,
  output logic              vid_v_sync,
  output logic              vid_h,
  output logic              vid_v,
  output logic              vid_f,
  output logic              underflow,
  output logic              sync_err,
  input  logic              flag_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [AW:0]   FIFO_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic          SYNC_ON      = (SYNC_POL != 0);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, RUN} state_t;

  state_t state, state_d;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic [DATA_W+1:0] head;
  logic              head_sop, head_eop, empty, full, push, pop;

  logic              h_act, v_act, active, at_first, at_last, at_end, hs_act, vs_act;
  logic              px_drive, set_under, set_sync;
  logic [DATA_W-1:0] px_data;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FIFO_FULL);
  assign din_ready = enable && !full;
  assign push      = din_valid && din_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_sop  = head[DATA_W+1];
  assign head_eop  = head[DATA_W];

  assign h_act    = (h_cnt <= H_ACT_LAST);
  assign v_act    = (v_cnt <= V_ACT_LAST);
  assign active   = h_act && v_act;
  assign at_first = (h_cnt == '0) && (v_cnt == '0);
  assign at_last  = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  assign at_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_act   = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
  assign vs_act   = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);

  assign vid_f = 1'b0;

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    px_drive  = 1'b0;
    px_data   = '0;
    set_under = 1'b0;
    set_sync  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_d = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (!empty) begin
          if (!head_sop)   pop = 1'b1;
          else if (at_end) state_d = RUN;
        end
      end
      RUN: begin
        if (active) begin
          if (empty) begin
            px_drive  = 1'b1;
            set_under = 1'b1;
            state_d   = WAIT_SOP;
          end else if (head_sop && !at_first) begin
            // next frame's SOP stays at the head so WAIT_SOP can lock onto it
            set_sync = 1'b1;
            state_d  = WAIT_SOP;
          end else begin
            pop      = 1'b1;
            px_drive = 1'b1;
            px_data  = head[DATA_W-1:0];
            if (head_eop != at_last) begin
              set_sync = 1'b1;
              state_d  = WAIT_SOP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d   = IDLE;
      pop       = 1'b0;
      px_drive  = 1'b0;
      set_under = 1'b0;
      set_sync  = 1'b0;
    end
  end

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_d;
      if (!enable || state == IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge vid_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {din_sop, din_eop, din_data};
  end

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      vid_data      <= '0;
      vid_datavalid <= 1'b0;
      vid_h         <= 1'b0;
      vid_v         <= 1'b0;
      vid_h_sync    <= ~SYNC_ON;
      vid_v_sync    <= ~SYNC_ON;
    end else if (!enable || state == IDLE) begin
      vid_data      <= '0;
      vid_datavalid <= 1'b0;
      vid_h         <= 1'b0;
      vid_v         <= 1'b0;
      vid_h_sync    <= ~SYNC_ON;
      vid_v_sync    <= ~SYNC_ON;
    end else begin
      vid_data      <= px_data;
      vid_datavalid <= px_drive;
      vid_h         <= !h_act;
      vid_v         <= !v_act;
      vid_h_sync    <= hs_act ? SYNC_ON : ~SYNC_ON;
      vid_v_sync    <= vs_act ? SYNC_ON : ~SYNC_ON;
    end
  end

  // a set in the same clock as flag_clr takes priority
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (set_under)     underflow <= 1'b1;
      else if (flag_clr) underflow <= 1'b0;
      if (set_sync)      sync_err  <= 1'b1;
      else if (flag_clr) sync_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_timing_out.sv
// Bench for vid_timing_out on a 7x5 (4x2 active) raster: frame-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vid_timing_out;

  localparam int DW = 24;
  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FD = 16;
  localparam logic SP = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic flag_clr = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic din_ready;
  logic [DW-1:0] vid_data;
  logic vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, vid_f, underflow, sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vid_timing_out #(
    .DATA_W(DW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0), .FIFO_DEPTH(FD)
  ) dut (
    .vid_clk(clk), .reset(rst), .enable(enable),
    .din_data(din_data), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
    .din_ready(din_ready), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_h(vid_h), .vid_v(vid_v),
    .vid_f(vid_f), .underflow(underflow), .sync_err(sync_err), .flag_clr(flag_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // source: beats leave the queue once the DUT has accepted them
  beat_t src_q[$];
  logic  acc = 1'b0;

  always @(negedge clk) acc = din_valid && din_ready;

  always begin
    @(posedge clk);
    #2;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      din_valid = 1'b1;
      din_data  = src_q[0].d;
      din_sop   = src_q[0].sop;
      din_eop   = src_q[0].eop;
    end else begin
      din_valid = 1'b0;
      din_data  = '0;
      din_sop   = 1'b0;
      din_eop   = 1'b0;
    end
  end

  task automatic add_frame(input logic [DW-1:0] base, input int n, input int eop_at);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d   = base + DW'(i);
      b.sop = (i == 0);
      b.eop = (i == eop_at);
      src_q.push_back(b);
    end
  endtask

  // reference model: position in frame from a free-running pixel index, FIFO as a queue
  beat_t mq[$];
  bit    m_idle = 1'b1, m_run = 1'b0, m_u = 1'b0, m_s = 1'b0;
  int    m_t = 0;
  logic [DW-1:0] e_data = '0;
  logic e_dv = 1'b0, e_h = 1'b0, e_v = 1'b0, e_hs = ~SP, e_vs = ~SP, e_u = 1'b0, e_s = 1'b0;

  int            mh, mv, midx;
  bit            mpush, msu, mss, mdv, mhb, mvb, mhs, mvs;
  logic [DW-1:0] md;
  beat_t         mnb, mhead;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_idle = 1'b1; m_run = 1'b0; m_t = 0; m_u = 1'b0; m_s = 1'b0;
      e_data <= '0; e_dv <= 1'b0; e_h <= 1'b0; e_v <= 1'b0;
      e_hs <= ~SP; e_vs <= ~SP; e_u <= 1'b0; e_s <= 1'b0;
    end else begin
      mpush = din_valid && enable && (mq.size() < FD);
      mnb.d = din_data; mnb.sop = din_sop; mnb.eop = din_eop;
      msu = 1'b0; mss = 1'b0; mdv = 1'b0; md = '0;
      mhb = 1'b0; mvb = 1'b0; mhs = ~SP; mvs = ~SP;
      if (!enable) begin
        mq.delete();
        m_idle = 1'b1; m_run = 1'b0; m_t = 0;
        mpush = 1'b0;
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else begin
        mh = m_t % HT;
        mv = m_t / HT;
        mhb = (mh >= HA);
        mvb = (mv >= VA);
        mhs = (mh >= HA + HF && mh < HA + HF + HS) ? SP : ~SP;
        mvs = (mv >= VA + VF && mv < VA + VF + VS) ? SP : ~SP;
        if (m_run) begin
          if (mh < HA && mv < VA) begin
            midx = mv * HA + mh;
            if (mq.size() == 0) begin
              mdv = 1'b1; msu = 1'b1; m_run = 1'b0;
            end else if (mq[0].sop && midx != 0) begin
              mss = 1'b1; m_run = 1'b0;
            end else begin
              mhead = mq.pop_front();
              mdv = 1'b1; md = mhead.d;
              if (mhead.eop != (midx == HA * VA - 1)) begin
                mss = 1'b1; m_run = 1'b0;
              end
            end
          end
        end else if (mq.size() > 0) begin
          if (!mq[0].sop) void'(mq.pop_front());
          else if (m_t == HT * VT - 1) m_run = 1'b1;
        end
        m_t = (m_t + 1) % (HT * VT);
      end
      if (mpush) mq.push_back(mnb);
      if (msu) m_u = 1'b1; else if (flag_clr) m_u = 1'b0;
      if (mss) m_s = 1'b1; else if (flag_clr) m_s = 1'b0;
      e_data <= md; e_dv <= mdv; e_h <= mhb; e_v <= mvb;
      e_hs <= mhs; e_vs <= mvs; e_u <= m_u; e_s <= m_s;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cycle",
          {31'd0, vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, vid_f,
           underflow, sync_err, din_ready},
          {31'd0, e_data, e_dv, e_hs, e_vs, e_h, e_v, 1'b0, e_u, e_s,
           (enable && (mq.size() < FD))});
    end
  end

  task automatic wait_dv(input string tag, output logic [DW-1:0] d, output logic hv);
    logic prev;
    bit   found;
    prev = 1'b0; found = 1'b0; d = '0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(negedge clk);
      if (vid_datavalid) begin
        found = 1'b1;
        d = vid_data;
      end else begin
        prev = vid_h && vid_v;
      end
    end
    hv = prev;
    if (!found) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic restart();
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 src_q.delete();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          hv;
    logic [DW-1:0] got [8];
    int            k, hs_n, vs_n;

    repeat (2) @(negedge clk);
    chk("rst_hsync", vid_h_sync, 1);
    chk("rst_vsync", vid_v_sync, 1);
    chk("rst_ready", din_ready, 0);
    chk("rst_dv", vid_datavalid, 0);
    chk("rst_data", vid_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // continuous well-formed frames
    @(posedge clk); #1;
    add_frame(24'h100, 8, 7); add_frame(24'h110, 8, 7); add_frame(24'h120, 8, 7);
    enable = 1'b1;
    wait_dv("t1_first", d, hv);
    k = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i > 0) @(negedge clk);
      if (vid_datavalid) begin
        if (k < 8) got[k] = vid_data;
        k++;
      end
      if (!vid_h_sync) hs_n++;
      if (!vid_v_sync) vs_n++;
    end
    chk("t1_dv_per_frame", k, 8);
    chk("t1_hsync_clks", hs_n, 5);
    chk("t1_vsync_clks", vs_n, 7);
    for (int i = 0; i < 8; i++) chk("t1_pixel", got[i], 24'h100 + i);
    chk("t1_underflow", underflow, 0);
    chk("t1_sync_err", sync_err, 0);

    // stream joined mid-frame: leading non-SOP beats dropped
    restart();
    src_q.push_back('{d: 24'h0A1, sop: 1'b0, eop: 1'b0});
    src_q.push_back('{d: 24'h0A2, sop: 1'b0, eop: 1'b1});
    add_frame(24'h200, 8, 7);
    enable = 1'b1;
    wait_dv("t2_first", d, hv);
    chk("t2_sop_pixel", d, 24'h200);
    chk("t2_from_blank", hv, 1);
    repeat (30) @(negedge clk);
    chk("t2_sync_err", sync_err, 0);

    // source stall at pixel 5
    restart();
    add_frame(24'h300, 5, -1);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_dv("t3_px", d, hv);
      chk("t3_pixel", d, (i < 5) ? 24'h300 + i : 24'h0);
    end
    chk("t3_underflow_set", underflow, 1);
    @(posedge clk); #1 add_frame(24'h310, 8, 7);
    wait_dv("t3_resume", d, hv);
    chk("t3_resume_pixel", d, 24'h310);
    @(posedge clk); #1 flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    @(negedge clk);
    chk("t3_underflow_clr", underflow, 0);

    // early EOP, then realignment and clear-vs-set priority
    restart();
    add_frame(24'h400, 8, 3); add_frame(24'h410, 8, 3);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_dv("t4_px", d, hv);
      chk("t4_pixel", d, 24'h400 + i);
    end
    chk("t4_sync_err_set", sync_err, 1);
    @(posedge clk); #1 flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    @(negedge clk);
    chk("t4_sync_err_clr", sync_err, 0);
    wait_dv("t4_realign", d, hv);
    chk("t4_realign_pixel", d, 24'h410);
    chk("t4_realign_blank", hv, 1);
    @(posedge clk);
    @(posedge clk); #1 flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    @(negedge clk);
    chk("t4_set_wins", sync_err, 1);

    // enable dropped mid-frame
    @(posedge clk); #1 enable = 1'b0;
    #1 chk("t6_ready_drop", din_ready, 0);
    @(posedge clk); #1;
    chk("t6_en_dv", vid_datavalid, 0);
    chk("t6_en_h", vid_h, 0);
    chk("t6_en_v", vid_v, 0);
    chk("t6_en_hsync", vid_h_sync, 1);
    chk("t6_en_vsync", vid_v_sync, 1);
    chk("t6_en_data", vid_data, 0);
    chk("t6_en_sync_err_kept", sync_err, 1);

    // FIFO fills while WAIT_SOP holds the SOP head, then streams with push+pop
    @(posedge clk); #1;
    src_q.delete();
    add_frame(24'h500, 8, 7); add_frame(24'h510, 8, 7); add_frame(24'h520, 8, 7);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_full_ready", din_ready, 0);
    wait_dv("t5_first", d, hv);
    chk("t5_pixel", d, 24'h500);
    repeat (37) @(negedge clk);
    chk("t5_mid_line_dv", vid_datavalid, 1);

    // asynchronous reset mid-line
    @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
    #1;
    chk("t6_rst_dv", vid_datavalid, 0);
    chk("t6_rst_data", vid_data, 0);
    chk("t6_rst_hsync", vid_h_sync, 1);
    chk("t6_rst_vsync", vid_v_sync, 1);
    chk("t6_rst_h", vid_h, 0);
    chk("t6_rst_ready", din_ready, 0);
    chk("t6_rst_sync_err", sync_err, 0);
    chk("t6_rst_underflow", underflow, 0);
    @(posedge clk); #1 rst = 1'b0; src_q.delete();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_timing_out.md
Name: vid_timing_out

Overview:
- Parametrised clocked-video output stage that drives the LCD panel from a pixel stream delivered by the frame reader.
- Generates programmable h/v timing, buffers input pixels in a small FIFO and locks the stream to the frame start.
- Unlike the fixed ITC it flags underflow and SOP/EOP misalignment, then resynchronises automatically.
- Runs in the video clock domain, between the pixel source and the panel pins.

Parameters:
DATA_W, 24, pixel width in bits
H_ACTIVE, 800, active pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 48, hsync width (clocks)
H_BP, 40, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 29, vertical back porch (lines)
SYNC_POL, 0, sync polarity: 0 = syncs active-low, 1 = active-high
FIFO_DEPTH, 16, input FIFO entries; power of two, at least 4

Ports:
vid_clk  in  1  video pixel clock
reset  in  1  asynchronous active-high reset
enable  in  1  1 = run timing and output
din_data  in  DATA_W  input pixel
din_valid  in  1  input beat valid
din_sop  in  1  first pixel of frame
din_eop  in  1  last pixel of frame
din_ready  out  1  FIFO can accept a beat
vid_data  out  DATA_W  pixel to panel
vid_datavalid  out  1  active pixel being driven
vid_h_sync  out  1  hsync, polarity set by SYNC_POL
vid_v_sync  out  1  vsync, polarity set by SYNC_POL
vid_h  out  1  high outside horizontal active region
vid_v  out  1  high outside vertical active region
vid_f  out  1  field flag; always 0 (progressive only)
underflow  out  1  sticky underflow flag
sync_err  out  1  sticky SOP/EOP misalignment flag
flag_clr  in  1  one-clock pulse, clears both sticky flags

Behaviour:
- Reset is asynchronous, active-high.
- Reset values:
  - vid_data = 0; vid_datavalid, vid_h, vid_v, vid_f, underflow, sync_err = 0.
  - Syncs held at the inactive level; din_ready = 0.
  - FIFO empty; h_cnt = v_cnt = 0; state = IDLE.
- Counters (run only while enable = 1):
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On h_cnt wrap, v_cnt increments over 0..V_TOTAL-1 and wraps to 0.
  - Region order within a line and within a frame: active, front porch, sync, back porch.
- hsync is asserted when h_cnt lies in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the equivalent rule on v_cnt.
- All video outputs are registered. Latency from counter value to pins is exactly 1 clock.
- din_ready = FIFO not full, and enable = 1. A beat is written when din_valid and din_ready are both high. Input data, sop and eop are stored together per entry.
- State machine:
  - IDLE: counters and FIFO held at reset values, outputs inactive. Leaves to WAIT_SOP when enable = 1.
  - WAIT_SOP: the FIFO head is popped and discarded whenever it is not SOP. Moves to RUN when the head is SOP and (h_cnt, v_cnt) = (H_TOTAL-1, V_TOTAL-1), so the SOP pixel is driven on pixel (0,0).
  - RUN: one entry is popped per active pixel.
- Underflow in RUN: FIFO empty on an active pixel.
  - Drive vid_data = 0 with vid_datavalid = 1.
  - Set underflow and go to WAIT_SOP. Timing continues without interruption.
- Misalignment in RUN sets sync_err and goes to WAIT_SOP. Misalignment is any of:
  - a popped pixel with eop = 1 that is not the last active pixel;
  - the last active pixel with eop = 0;
  - a non-first pixel with sop = 1.
  - In the sop case the SOP entry is kept at the FIFO head, not dropped.
- Boundary cases:
  - FIFO full: din_ready = 0, no write.
  - Push and pop in the same clock: both happen, occupancy unchanged.
  - flag_clr in the same clock as a set: set wins.
  - enable deasserted mid-frame: go to IDLE next clock, flush FIFO, outputs and counters return to reset values; sticky flags are kept.
  - reset mid-frame: immediate return to all reset values.
- Widths: counters are sized by clog2 of the totals. Parameters are compile-time values; there is no runtime mode change.

Test Plan:
1. Small config (H 4/1/1/1, V 2/1/1/1), enable, continuous valid frames with correct SOP/EOP -> hsync low for 1 clk per 7-clk line; datavalid high 4 clks per line on 2 lines; pixel values match input order; underflow = sync_err = 0.
2. Frame started mid-stream (first beats are non-SOP) -> those beats are dropped; the first driven pixel at (0,0) is the SOP beat, 1 clk after counters read (6,4).
3. Source stalls at pixel 5 of frame -> that pixel is driven as 0 with datavalid = 1; underflow = 1; next correct frame resumes output; flag_clr pulse -> underflow = 0.
4. EOP on pixel 3 of 8 -> sync_err = 1, WAIT_SOP entered; next SOP aligns to (0,0); flag_clr coincident with a new error -> sync_err stays 1.
5. Fill FIFO with no pops (enable = 1 during porch) -> din_ready falls after FIFO_DEPTH writes; then simultaneous push/pop keeps occupancy constant.
6. Assert reset mid-line and, separately, drop enable mid-frame -> all outputs return to reset values at once (reset) or next clk (enable); flags kept on enable drop, cleared on reset.
